// File: rtl/rc4_ctrl_pkg.sv
// Shared types and default sizing for the RC4 key-search control block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rc4_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FOUND,
        EXHAUSTED
    } dispatch_state_t;

    localparam int CORE_COUNT_LOG_2_DEF = 7;
    localparam int KEY_WIDTH_DEF        = 22;
    localparam int BLOCK_LOG_2_DEF      = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set req bit at or after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is consumed.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    // Doubling the request vector turns the wrap-around search into a plain slice.
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [W-1:0]   offset;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N];

    // Lowest set bit of the rotated vector is the distance from ptr to the winner.
    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = W'(i);
            end
        end
    end

    // N is a power of two, so the W-bit add wraps back onto the real index.
    assign any = |req;
    assign idx = ptr + offset;
    assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/key_space_dispatcher.sv
// Hands out key blocks to cores round-robin, detects exhaustion, latches the first winner.
// Latency: req -> grant 1 cycle; found -> key_found/stop_all 1 cycle; at most one grant per cycle.
// Backpressure: cores hold req until granted; a found or an empty key space stops all grants.
module key_space_dispatcher
    import rc4_ctrl_pkg::*;
#(
    parameter int CORE_COUNT_LOG_2 = CORE_COUNT_LOG_2_DEF,
    parameter int CORE_COUNT       = 2 ** CORE_COUNT_LOG_2,
    parameter int KEY_WIDTH        = KEY_WIDTH_DEF,
    parameter int BLOCK_LOG_2      = BLOCK_LOG_2_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CORE_COUNT-1:0]           req,
    input  logic [CORE_COUNT-1:0]           core_busy,
    input  logic [CORE_COUNT-1:0]           found,
    input  logic [CORE_COUNT*KEY_WIDTH-1:0] found_key,
    output logic [CORE_COUNT-1:0]           grant,
    output logic [KEY_WIDTH-1:0]            grant_base,
    output logic [KEY_WIDTH-1:0]            next_base,
    output logic                            stop_all,
    output logic                            key_found,
    output logic [KEY_WIDTH-1:0]            winning_key,
    output logic [CORE_COUNT_LOG_2-1:0]     winning_core,
    output logic                            exhausted,
    output logic                            busy
);

    localparam logic [KEY_WIDTH-1:0] BLOCK_SIZE = KEY_WIDTH'(1) << BLOCK_LOG_2;
    localparam logic [KEY_WIDTH-1:0] LAST_BASE  = ~(BLOCK_SIZE - KEY_WIDTH'(1));

    dispatch_state_t               state;
    dispatch_state_t               state_next;
    logic [CORE_COUNT_LOG_2-1:0]   rr_ptr;
    logic                          issue_done;
    logic                          do_grant;
    logic                          latch_found;

    logic [CORE_COUNT-1:0]         eligible;
    logic [CORE_COUNT-1:0]         arb_gnt;
    logic [CORE_COUNT_LOG_2-1:0]   arb_idx;
    logic                          arb_any;

    logic                          found_any;
    logic [CORE_COUNT_LOG_2-1:0]   found_idx;
    logic [KEY_WIDTH-1:0]          found_sel_key;

    // A core whose grant is still showing keeps req up for this cycle; mask it out.
    assign eligible = req & ~grant;

    rr_arbiter #(
        .N (CORE_COUNT),
        .W (CORE_COUNT_LOG_2)
    ) u_rr_arbiter (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Lowest-index reporter wins when several cores find a key in the same cycle.
    always_comb begin
        found_idx = '0;
        for (int i = CORE_COUNT - 1; i >= 0; i--) begin
            if (found[i]) begin
                found_idx = CORE_COUNT_LOG_2'(i);
            end
        end
        found_any     = |found;
        found_sel_key = found_key[int'(found_idx) * KEY_WIDTH +: KEY_WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; found outranks a grant in the same cycle.
    always_comb begin
        state_next  = state;
        do_grant    = 1'b0;
        latch_found = 1'b0;
        busy        = 1'b0;
        stop_all    = 1'b0;
        key_found   = 1'b0;
        exhausted   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (found_any) begin
                    state_next  = FOUND;
                    latch_found = 1'b1;
                end else if (arb_any && !issue_done) begin
                    do_grant = 1'b1;
                    if (next_base == LAST_BASE) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (found_any) begin
                    state_next  = FOUND;
                    latch_found = 1'b1;
                end else if (core_busy == '0) begin
                    state_next = EXHAUSTED;
                end
            end
            FOUND: begin
                stop_all  = 1'b1;
                key_found = 1'b1;
            end
            EXHAUSTED: begin
                stop_all  = 1'b1;
                exhausted = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant pulse, key-space cursor, arbitration pointer and winner latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant        <= '0;
            grant_base   <= '0;
            next_base    <= '0;
            rr_ptr       <= '0;
            issue_done   <= 1'b0;
            winning_key  <= '0;
            winning_core <= '0;
        end else begin
            grant <= '0;
            if (do_grant) begin
                grant      <= arb_gnt;
                grant_base <= next_base;
                next_base  <= next_base + BLOCK_SIZE;
                rr_ptr     <= arb_idx + CORE_COUNT_LOG_2'(1);
                if (next_base == LAST_BASE) begin
                    issue_done <= 1'b1;
                end
            end
            if (latch_found) begin
                winning_key  <= found_sel_key;
                winning_core <= found_idx;
            end
        end
    end

endmodule
